deserializer: RTL and testbench



---
 rtl/deserializer_pkg.sv | 12 +
 rtl/deser_shift_reg.sv | 35 +++
 rtl/deserializer.sv | 61 ++++++
 tb/tb_deserializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the bit-serial to word deserializer.
// Imported by deser_shift_reg and deserializer.
package deserializer_pkg;

  typedef enum logic {
    COLLECT,
    READY
  } deser_state_t;

  localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/deser_shift_reg.sv
// MSB-first shift register with bit counter; flags the DATA_W-th bit.
// Ports: clock_100k, reset (async low), shift_en, data_in -> word, last_bit.
module deser_shift_reg
  import deserializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock_100k,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              data_in,
  output logic [DATA_W-1:0] word,
  output logic              last_bit
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     cnt_q;

  // word already includes the bit being sampled this edge
  assign word     = {shift_q[DATA_W-2:0], data_in};
  assign last_bit = shift_en && (cnt_q == CW'(DATA_W - 1));

  always_ff @(posedge clock_100k or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= word;
      cnt_q   <= last_bit ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel converter with ready/ack hold of the finished word.
// Ports: clock_100k, reset, data_in, write_in, ack_in -> data_out, data_ready.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock_100k,
  input  logic              reset,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              ack_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready
);

  deser_state_t      state_q;
  logic              shift_en;
  logic              last_bit;
  logic [DATA_W-1:0] word;

  // bits arriving while a word is held are dropped
  assign shift_en = write_in && (state_q == COLLECT);

  deser_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clock_100k(clock_100k),
    .reset     (reset),
    .shift_en  (shift_en),
    .data_in   (data_in),
    .word      (word),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clock_100k or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      data_out   <= '0;
      data_ready <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (last_bit) begin
            data_out   <= word;
            data_ready <= 1'b1;
            state_q    <= READY;
          end
        end
        READY: begin
          if (ack_in) begin
            data_ready <= 1'b0;
            state_q    <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed scoreboard bench for deserializer.
// Drives on negedge, samples on negedge before the next drive.
module tb_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       ack_in = 1'b0;
  logic [7:0] data_out;
  logic       data_ready;

  int         checks = 0;
  int         errors = 0;
  int         rises = 0;
  logic       ready_prev = 1'b0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  deserializer #(
    .DATA_W(8)
  ) dut (
    .clock_100k(clk),
    .reset     (reset),
    .data_in   (data_in),
    .write_in  (write_in),
    .ack_in    (ack_in),
    .data_out  (data_out),
    .data_ready(data_ready)
  );

  always @(negedge clk) begin
    if (data_ready && !ready_prev) rises++;
    ready_prev = data_ready;
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    write_in = 1'b1;
    data_in  = b;
    @(negedge clk);
    write_in = 1'b0;
    data_in  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input bit push);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    if (push) sb.push_back(w);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
  endtask

  task automatic expect_word(input string tag);
    int n;
    logic [7:0] exp;
    n = 0;
    while (!data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      checks++;
      errors++;
      $display("FAIL %s data_ready observed 0 expected 1 (timeout)", tag);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard observed empty expected entry", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, data_out, exp);
    end
  endtask

  initial begin
    // 1: reset
    repeat (2) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_ready", 8'(data_ready), 8'h00);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_data", data_out, 8'h00);
    check("idle_ready", 8'(data_ready), 8'h00);

    // 2: 0xAD, ready right after last sample, ack
    send_word(8'hAD, 1'b1);
    check("t2_latency", 8'(data_ready), 8'h01);
    expect_word("t2_word");
    do_ack();
    @(negedge clk);
    check("t2_ack_ready", 8'(data_ready), 8'h00);
    check("t2_ack_hold", data_out, 8'hAD);

    // 3: extra bits in READY are dropped
    send_word(8'hAD, 1'b1);
    expect_word("t3_word1");
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t3_hold", data_out, 8'hAD);
    check("t3_ready", 8'(data_ready), 8'h01);
    do_ack();
    send_word(8'h3C, 1'b1);
    expect_word("t3_word2");

    // 4: reset mid-word discards partial bits
    do_ack();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t4_no_partial", data_out, 8'h3C);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t4_rst_data", data_out, 8'h00);
    check("t4_rst_ready", 8'(data_ready), 8'h00);
    @(negedge clk);
    reset = 1'b1;
    send_word(8'h5A, 1'b1);
    expect_word("t4_word");

    // 5: ack during COLLECT has no effect
    do_ack();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    do_ack();
    check("t5_mid_ready", 8'(data_ready), 8'h00);
    check("t5_mid_data", data_out, 8'h5A);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    sb.push_back(8'hF0);
    expect_word("t5_word");

    // 6: back-to-back with write_in held high
    do_ack();
    @(negedge clk);
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      write_in = 1'b1;
      data_in  = 1'b1;
      @(negedge clk);
    end
    sb.push_back(8'hFF);
    check("t6_latency", 8'(data_ready), 8'h01);
    expect_word("t6_ff");
    ack_in  = 1'b1;
    data_in = 1'b0;
    @(negedge clk);
    check("t6_ack_ready", 8'(data_ready), 8'h00);
    ack_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
    end
    write_in = 1'b0;
    sb.push_back(8'h00);
    check("t6_latency2", 8'(data_ready), 8'h01);
    expect_word("t6_00");
    repeat (3) @(negedge clk);
    check("t6_rises", 8'(rises), 8'h02);
    check("t6_hold", data_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
